rename_ctrl: RTL and testbench

- Sequencing controller for the rename stage and its physical-register free list.
- Gates decode-to-rename allocation on free-register availability, with a reserve margin.
- Arbitrates the free list's single free port between ROB commit frees and squash-walk frees.
- Sequences post-reset init and branch-flush recovery. Sits between decode, ROB and the rename/freelist pair.

---
 rtl/rename_pkg.sv | 9 +
 rtl/rename_ctrl_free_port_arb.sv | 33 +++
 rtl/rename_ctrl.sv | 98 +++++++++
 tb/tb_rename_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rename_pkg: shared types and sizes for the rename controller and its free-port arbiter.
package rename_pkg;
  localparam int NUM_PREGS = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W = $clog2(NUM_PREGS + 1);
  typedef logic [ADDR_W-1:0] preg_addr_t;
  localparam preg_addr_t PREG_ZERO = '0;
  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_e;
endpackage

// File: rtl/rename_ctrl_free_port_arb.sv
// free_port_arb: grants the single free-list push port to commit or squash frees,
// with a starvation counter that lets commit through during long squash walks.
module free_port_arb
  import rename_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  state_e     mode_i,
  input  logic       c_valid_i,
  input  preg_addr_t c_addr_i,
  input  logic       s_valid_i,
  input  preg_addr_t s_addr_i,
  output logic       c_grant_o,
  output logic       s_grant_o,
  output preg_addr_t grant_addr_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic starve_max;
  always_comb begin
    starve_max = starve_q == SW'(STARVE_MAX);
    c_grant_o = (mode_i == RUN) ? c_valid_i :
                (mode_i == FLUSH) ? c_valid_i & (~s_valid_i | starve_max) : 1'b0;
    s_grant_o = (mode_i == FLUSH) & s_valid_i & ~c_grant_o;
    grant_addr_o = c_grant_o ? c_addr_i : s_grant_o ? s_addr_i : PREG_ZERO;
    starve_d = c_grant_o ? '0 : (c_valid_i & ~starve_max) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) starve_q <= '0;
    else starve_q <= starve_d;
endmodule

// File: rtl/rename_ctrl.sv
// rename_ctrl: rename-stage sequencer (INIT/RUN/FLUSH), allocation gate and shadow free count.
// Optional perf counters are enabled with RENAME_CTRL_PERF_EN.
module rename_ctrl
  import rename_pkg::*;
#(
  parameter int RESERVE = 1,
  parameter int INIT_CYCLES = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  output logic             fl_alloc_en_o,
  input  logic             commit_free_valid_i,
  input  preg_addr_t       commit_free_addr_i,
  output logic             commit_free_ready_o,
  input  logic             squash_free_valid_i,
  input  preg_addr_t       squash_free_addr_i,
  output logic             squash_free_ready_o,
  input  logic             flush_i,
  input  logic             squash_done_i,
  output logic             fl_free_en_o,
  output preg_addr_t       fl_free_addr_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] free_count_o,
  output logic             err_o
`ifdef RENAME_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_stall_empty_o,
  output logic [31:0]      perf_flush_cycles_o
`endif
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  state_e state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic err_q, err_d;
  logic grant, push, inc, dec, full, empty;
  free_port_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .mode_i       (state_q),
    .c_valid_i    (commit_free_valid_i),
    .c_addr_i     (commit_free_addr_i),
    .s_valid_i    (squash_free_valid_i),
    .s_addr_i     (squash_free_addr_i),
    .c_grant_o    (commit_free_ready_o),
    .s_grant_o    (squash_free_ready_o),
    .grant_addr_o (fl_free_addr_o)
  );
  always_comb begin
    dec_ready_o = (state_q == RUN) & (count_q > CNT_W'(RESERVE)) & ~flush_i;
    fl_alloc_en_o = dec_valid_i & dec_ready_o;
    grant = commit_free_ready_o | squash_free_ready_o;
    push = grant & (fl_free_addr_o != PREG_ZERO);
    fl_free_en_o = push;
    busy_o = state_q != RUN;
    free_count_o = count_q;
    err_o = err_q;
    full = count_q == CNT_W'(NUM_PREGS - 1);
    empty = count_q == '0;
    inc = push & ~fl_alloc_en_o;
    dec = fl_alloc_en_o & ~push;
    count_d = (inc & ~full) ? count_q + 1'b1 : (dec & ~empty) ? count_q - 1'b1 : count_q;
    // a p0 free is acked but flagged, alongside overflow/underflow
    err_d = err_q | (grant & ~push) | (inc & full) | (dec & empty);
    init_cnt_d = (state_q == INIT) ? init_cnt_q + 1'b1 : init_cnt_q;
    state_d = (state_q == INIT) ? ((init_cnt_q == IW'(INIT_CYCLES - 1)) ? RUN : INIT) :
              (state_q == RUN) ? (flush_i ? FLUSH : RUN) :
              (squash_done_i & ~squash_free_valid_i) ? RUN : FLUSH;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state_q <= INIT;
      init_cnt_q <= '0;
      count_q <= CNT_W'(NUM_PREGS - 1);
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_cnt_q <= init_cnt_d;
      count_q <= count_d;
      err_q <= err_d;
    end
`ifdef RENAME_CTRL_PERF_EN
  logic [31:0] stall_q, flush_cyc_q;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      stall_q <= '0;
      flush_cyc_q <= '0;
    end else begin
      stall_q <= stall_q + 32'((state_q == RUN) & dec_valid_i & (count_q <= CNT_W'(RESERVE)));
      flush_cyc_q <= flush_cyc_q + 32'(state_q == FLUSH);
    end
  assign perf_stall_empty_o = stall_q;
  assign perf_flush_cycles_o = flush_cyc_q;
`endif
endmodule

// File: tb/tb_rename_ctrl.sv
// tb_rename_ctrl: directed vectors for rename_ctrl; expectations are queued by the
// stimulus and popped/compared by an independent monitor on the falling edge.
module tb_rename_ctrl;
  typedef struct packed {
    logic       rdy;
    logic       al;
    logic       cr;
    logic       sr;
    logic       fe;
    logic [4:0] fa;
    logic       busy;
    logic [5:0] cnt;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic dec_valid_i = 1'b0, commit_free_valid_i = 1'b0, squash_free_valid_i = 1'b0;
  logic [4:0] commit_free_addr_i = '0, squash_free_addr_i = '0;
  logic flush_i = 1'b0, squash_done_i = 1'b0;
  logic dec_ready_o, fl_alloc_en_o, commit_free_ready_o, squash_free_ready_o;
  logic fl_free_en_o, busy_o, err_o;
  logic [4:0] fl_free_addr_o;
  logic [5:0] free_count_o;

  exp_t exp_q[$];
  string name_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rename_ctrl dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .dec_valid_i         (dec_valid_i),
    .dec_ready_o         (dec_ready_o),
    .fl_alloc_en_o       (fl_alloc_en_o),
    .commit_free_valid_i (commit_free_valid_i),
    .commit_free_addr_i  (commit_free_addr_i),
    .commit_free_ready_o (commit_free_ready_o),
    .squash_free_valid_i (squash_free_valid_i),
    .squash_free_addr_i  (squash_free_addr_i),
    .squash_free_ready_o (squash_free_ready_o),
    .flush_i             (flush_i),
    .squash_done_i       (squash_done_i),
    .fl_free_en_o        (fl_free_en_o),
    .fl_free_addr_o      (fl_free_addr_o),
    .busy_o              (busy_o),
    .free_count_o        (free_count_o),
    .err_o               (err_o)
  );

  exp_t act;
  assign act = '{dec_ready_o, fl_alloc_en_o, commit_free_ready_o, squash_free_ready_o,
                 fl_free_en_o, fl_free_addr_o, busy_o, free_count_o, err_o};

  function automatic exp_t mk(logic rdy, logic al, logic cr, logic sr, logic fe,
                              logic [4:0] fa, logic busy, logic [5:0] cnt, logic err);
    return '{rdy, al, cr, sr, fe, fa, busy, cnt, err};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s got rdy=%b al=%b cr=%b sr=%b fe=%b fa=%0d busy=%b cnt=%0d err=%b | want rdy=%b al=%b cr=%b sr=%b fe=%b fa=%0d busy=%b cnt=%0d err=%b",
                 nm, act.rdy, act.al, act.cr, act.sr, act.fe, act.fa, act.busy, act.cnt, act.err,
                 e.rdy, e.al, e.cr, e.sr, e.fe, e.fa, e.busy, e.cnt, e.err);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic dv, input logic cv,
                      input logic [4:0] ca, input logic sv, input logic [4:0] sa,
                      input logic fl, input logic sd, input exp_t e);
    @(posedge clk);
    #1;
    reset_i = rst;
    dec_valid_i = dv;
    commit_free_valid_i = cv;
    commit_free_addr_i = ca;
    squash_free_valid_i = sv;
    squash_free_addr_i = sa;
    flush_i = fl;
    squash_done_i = sd;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    // reset held, then INIT for two cycles with commit frees refused
    step("rst_vals", 0, 1, 1, 4, 0, 0, 0, 0, mk(0,0,0,0,0,0,1,31,0));
    step("init0",    1, 1, 1, 4, 0, 0, 0, 0, mk(0,0,0,0,0,0,1,31,0));
    step("init1",    1, 1, 1, 4, 0, 0, 0, 0, mk(0,0,0,0,0,0,1,31,0));
    for (int k = 0; k < 30; k++)
      step($sformatf("drain%0d", k), 1, 1, 0, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,0,6'(31-k),0));
    step("reserve_stall", 1, 1, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,1,0));
    step("commit_p7",     1, 1, 1, 7, 0, 0, 0, 0, mk(0,0,1,0,1,7,0,1,0));
    step("after_p7",      1, 0, 0, 0, 1, 5, 0, 0, mk(1,0,0,0,0,0,0,2,0));
    step("alloc_free_p9", 1, 1, 1, 9, 0, 0, 0, 0, mk(1,1,1,0,1,9,0,2,0));
    step("cnt_same",      1, 0, 0, 0, 0, 0, 0, 0, mk(1,0,0,0,0,0,0,2,0));
    step("flush_refuse",  1, 1, 0, 0, 0, 0, 1, 0, mk(0,0,0,0,0,0,0,2,0));
    step("sq_p3",  1, 1, 1, 10, 1, 3, 0, 0, mk(0,0,0,1,1,3,1,2,0));
    step("sq_p4",  1, 1, 1, 10, 1, 4, 1, 0, mk(0,0,0,1,1,4,1,3,0));
    step("sq_p5",  1, 1, 1, 10, 1, 5, 0, 0, mk(0,0,0,1,1,5,1,4,0));
    step("sq_p6",  1, 1, 1, 10, 1, 6, 0, 0, mk(0,0,0,1,1,6,1,5,0));
    step("starve_commit", 1, 1, 1, 10, 1, 7, 0, 0, mk(0,0,1,0,1,10,1,6,0));
    step("sq_p7",  1, 0, 1, 11, 1, 7, 0, 0, mk(0,0,0,1,1,7,1,7,0));
    step("sq_p8_done", 1, 0, 0, 0, 1, 8, 0, 1, mk(0,0,0,1,1,8,1,8,0));
    step("done",   1, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0,0,1,9,0));
    step("run_again", 1, 0, 0, 0, 0, 0, 0, 0, mk(1,0,0,0,0,0,0,9,0));
    step("commit_p0", 1, 0, 1, 0, 0, 0, 0, 0, mk(1,0,1,0,0,0,0,9,0));
    step("err_set",   1, 0, 0, 0, 0, 0, 0, 0, mk(1,0,0,0,0,0,0,9,1));
    step("err_sticky",1, 1, 0, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,0,9,1));
    step("flush2",    1, 0, 0, 0, 0, 0, 1, 0, mk(0,0,0,0,0,0,0,8,1));
    step("sq_p12",    1, 0, 0, 0, 1, 12, 0, 0, mk(0,0,0,1,1,12,1,8,1));
    // mid-cycle reset with a squash pending: values must change with no clock edge
    @(posedge clk);
    #1;
    squash_free_valid_i = 1'b1;
    squash_free_addr_i = 5'd13;
    #2;
    reset_i = 1'b0;
    exp_q.push_back(mk(0,0,0,0,0,0,1,31,0));
    name_q.push_back("async_rst");
    step("rst_hold",  0, 1, 0, 0, 1, 13, 0, 0, mk(0,0,0,0,0,0,1,31,0));
    step("reinit0",   1, 1, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,1,31,0));
    step("reinit1",   1, 1, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,1,31,0));
    step("rerun",     1, 1, 0, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,0,31,0));
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
